// File: rtl/traceback_ctrl.sv
// Viterbi traceback controller: traces TB_DEPTH survivor columns (2 cycles each), then emits the bits oldest-first under valid/ready.
// Optional TB_OVF_CNT_EN adds o_ovf_cnt, a saturating count of dropped survivor writes.
module traceback_ctrl #(
  parameter int TB_DEPTH  = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         i_en_t,
  input  logic                         i_td_wr,
  input  logic [1:0]                   i_best_state,
  input  logic                         i_surv_bit,
  input  logic                         i_ood,
  input  logic                         i_out_rdy,
  output logic                         o_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] o_rd_addr,
  output logic [1:0]                   o_rd_state,
  output logic                         o_bit_valid,
  output logic                         o_bit,
  output logic                         o_td_full,
  output logic                         o_ovf,
  output logic                         o_done
`ifdef TB_OVF_CNT_EN
  ,
  output logic [7:0]                   o_ovf_cnt
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(MEM_DEPTH + 1);
  localparam int LW = $clog2(TB_DEPTH + 1);
  localparam int SW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_UPD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_base;
  logic [AW-1:0]       r_col;
  logic [PW-1:0]       r_pend;
  logic [LW-1:0]       r_len;
  logic [SW-1:0]       r_step;
  logic [SW-1:0]       r_emit_idx;
  logic [1:0]          r_cur_state;
  logic [TB_DEPTH-1:0] r_lifo;
  logic                r_partial;
  logic                r_ovf;

  logic                w_full;
  logic                w_wr_acc;
  logic                w_wr_drop;
  logic                w_len_full;
  logic [LW-1:0]       w_blk_len;
  logic                w_step_last;
  logic                w_emit_last;
  logic                w_blk_start;
  logic                w_blk_partial;

  assign w_full      = (r_pend == PW'(MEM_DEPTH));
  assign w_wr_acc    = en & i_td_wr & ~w_full;
  assign w_wr_drop   = en & i_td_wr & w_full;
  assign w_len_full  = (r_pend >= PW'(TB_DEPTH));
  // A short block (ood flush) traces exactly the columns still pending.
  assign w_blk_len   = w_len_full ? LW'(TB_DEPTH) : LW'(r_pend);
  assign w_step_last = (LW'(r_step) == (r_len - LW'(1)));
  assign w_emit_last = (r_emit_idx == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_blk_start   = 1'b0;
    w_blk_partial = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: if (i_en_t) w_state_nxt = S_FILL;
        S_FILL: begin
          if (w_len_full) begin
            w_blk_start = 1'b1;
            w_state_nxt = S_RD;
          end else if (i_ood) begin
            if (r_pend != '0) begin
              w_blk_start   = 1'b1;
              w_blk_partial = 1'b1;
              w_state_nxt   = S_RD;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_RD:   w_state_nxt = S_UPD;
        S_UPD:  w_state_nxt = w_step_last ? S_EMIT : S_RD;
        S_EMIT: begin
          if (i_out_rdy && w_emit_last) w_state_nxt = r_partial ? S_DONE : S_FILL;
        end
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rd_en     = en && (r_state == S_RD);
    o_rd_addr   = o_rd_en ? r_col : '0;
    o_rd_state  = o_rd_en ? r_cur_state : 2'b00;
    o_bit_valid = en && (r_state == S_EMIT);
    o_bit       = (r_state == S_EMIT) ? r_lifo[r_emit_idx] : 1'b0;
    o_td_full   = w_full;
    o_ovf       = r_ovf;
    o_done      = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_base   <= '0;
      r_col       <= '0;
      r_pend      <= '0;
      r_len       <= '0;
      r_step      <= '0;
      r_emit_idx  <= '0;
      r_cur_state <= 2'b00;
      r_lifo      <= '0;
      r_partial   <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_wr_drop) r_ovf <= 1'b1;
      r_pend <= r_pend + PW'(w_wr_acc) - (w_blk_start ? PW'(w_blk_len) : PW'(0));

      if (w_blk_start) begin
        r_len       <= w_blk_len;
        r_cur_state <= i_best_state;
        r_col       <= r_rd_base + AW'(w_blk_len) - AW'(1);
        r_rd_base   <= r_rd_base + AW'(w_blk_len);
        r_step      <= '0;
        r_partial   <= w_blk_partial;
      end

      if (r_state == S_UPD) begin
        r_lifo[r_step] <= r_cur_state[1];
        r_cur_state    <= {r_cur_state[0], i_surv_bit};
        r_col          <= r_col - AW'(1);
        if (w_step_last) r_emit_idx <= SW'(r_len - LW'(1));
        else             r_step     <= r_step + SW'(1);
      end

      if ((r_state == S_EMIT) && i_out_rdy && !w_emit_last) r_emit_idx <= r_emit_idx - SW'(1);
    end
  end

`ifdef TB_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_wr_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: doc/traceback_ctrl.md
TRACEBACK_CTRL -- requirements
Module: traceback_ctrl

Interface
REQ-001 Parameter TB_DEPTH, default 8, sets the columns traced and bits emitted per traceback block.
REQ-002 Parameter MEM_DEPTH, default 16, is the survivor-memory column count; it shall be a power of two and at least TB_DEPTH.
REQ-003 Port clk, input, 1, is the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous and active-high.
REQ-005 Port en, input, 1, is the global enable; when low, all registers hold and o_rd_en and o_bit_valid are 0.
REQ-006 Port i_en_t, input, 1, is the traceback enable from the top-level controller.
REQ-007 Port i_td_wr, input, 1, indicates the ACS wrote one survivor column this cycle.
REQ-008 Port i_best_state, input, 2, gives the current minimum-metric state.
REQ-009 Port i_surv_bit, input, 1, is survivor-memory read data, valid one cycle after o_rd_en.
REQ-010 Port i_ood, input, 1, indicates out of data (input stream ended).
REQ-011 Port i_out_rdy, input, 1, is the downstream ready signal.
REQ-012 Ports o_rd_en (1), o_rd_addr (log2 MEM_DEPTH) and o_rd_state (2) are outputs forming the survivor-memory read request.
REQ-013 Ports o_bit_valid (1) and o_bit (1) are outputs carrying the decoded bit stream.
REQ-014 Ports o_td_full (1), o_ovf (1, sticky) and o_done (1) are status outputs.

Function
REQ-015 wr_ptr shall increment modulo MEM_DEPTH on each accepted i_td_wr (en=1, o_td_full=0), independent of FSM state.
REQ-016 pend (unread columns, 0..MEM_DEPTH) shall +1 per accepted write and -L at block start; a write and a block start in the same cycle shall give pend+1-L.
REQ-017 o_td_full shall be (pend == MEM_DEPTH); a write while full shall be dropped (no pointer/pend change) and shall set o_ovf.
REQ-018 The FSM shall have states IDLE, FILL, RD, UPD, EMIT and DONE.
REQ-019 IDLE shall move to FILL when i_en_t=1; i_en_t shall be sampled only in IDLE.
REQ-020 In FILL, when pend >= TB_DEPTH: L=TB_DEPTH; latch cur_state=i_best_state, col=rd_base+L-1, step=0, rd_base+=L; go to RD.
REQ-021 In FILL, when pend < TB_DEPTH and i_ood=1: if pend>0, start a partial block with L=pend (same as REQ-020); if pend=0, go to DONE.
REQ-022 RD shall assert o_rd_en for one cycle with o_rd_addr=col and o_rd_state=cur_state, then go to UPD.
REQ-023 UPD shall store lifo[step]=cur_state[1], set cur_state={cur_state[0], i_surv_bit}, and set col=col-1 mod MEM_DEPTH.
REQ-024 UPD shall then go to RD with step+1, or to EMIT if step=L-1; each traced column costs 2 cycles.
REQ-025 EMIT shall present o_bit=lifo[L-1] down to lifo[0] (oldest first) with o_bit_valid=1.
REQ-026 An EMIT bit shall advance only on o_bit_valid & i_out_rdy and shall be held stable otherwise.
REQ-027 After the last bit is transferred, EMIT shall go to DONE if the block was partial (ood flush), else to FILL.
REQ-028 DONE shall hold o_done=1 until reset.
REQ-029 i_ood asserting during RD/UPD/EMIT shall not abort the current block; it shall be acted on at the next FILL.

Reset
REQ-030 rst=1 at a clock edge shall force IDLE, wr_ptr=rd_base=pend=0, and lifo=0.
REQ-031 rst=1 at a clock edge shall force all outputs to 0, including mid-trace and mid-emit.
REQ-032 rst shall take priority over en.

Configuration
REQ-033 With TB_OVF_CNT_EN defined, port o_ovf_cnt (8-bit output) shall count dropped writes, saturating at 255, reset to 0.
REQ-034 Without TB_OVF_CNT_EN, the o_ovf_cnt port and its counter shall not exist; o_ovf behaviour is unchanged.

Verification
REQ-035 8 writes, best_state=2, survivor bits all 0, rdy=1 -> 8 RD reads at addr 7..0 with states 2,0,0,...; emitted bits 0,0,0,0,0,0,0,1 (oldest first).
REQ-036 16 writes with no traceback (i_en_t=0) -> o_td_full=1; 17th write dropped, o_ovf=1, o_ovf_cnt=1 when TB_OVF_CNT_EN is defined.
REQ-037 3 writes then i_ood=1 -> 3-step partial traceback at addr 2,1,0; 3 bits emitted; then o_done=1.
REQ-038 i_out_rdy low for 5 cycles mid-EMIT -> o_bit and o_bit_valid held; no bit lost or duplicated.
REQ-039 i_td_wr concurrent with a block start at pend=8 -> pend=1 next cycle; rst during UPD -> IDLE, all outputs 0 next cycle.
